// File: rtl/lane_car_counter_pkg.sv
// Shared lane-counter constants and types (lane order N1,N2,E1,E2,S1,S2,W1,W2).
// Optional overflow flags are enabled with CAR_OVF_FLAG_EN.
package lane_car_counter_pkg;
    localparam int NUM_LANES         = 8;
    localparam int CNT_W             = 8;
    localparam int DEPART_CYCLES_DEF = 4;

    localparam int LANE_N1 = 0;
    localparam int LANE_N2 = 1;
    localparam int LANE_E1 = 2;
    localparam int LANE_E2 = 3;
    localparam int LANE_S1 = 4;
    localparam int LANE_S2 = 5;
    localparam int LANE_W1 = 6;
    localparam int LANE_W2 = 7;

    typedef logic [CNT_W-1:0] car_cnt_t;
endpackage

// File: rtl/lane_car_counter_if.sv
// Sensor/selector bus for lane_car_counter; master drives sensors and green, slave is the counter.
// CAR_OVF_FLAG_EN adds the ovf_clr/ovf_flag pair.
interface lane_car_counter_if;
    import lane_car_counter_pkg::*;

    logic [NUM_LANES-1:0]            car_arrive;
    logic [NUM_LANES-1:0]            lane_green;
    car_cnt_t [NUM_LANES-1:0]        car_counts;
    logic [NUM_LANES-1:0]            lane_busy;
`ifdef CAR_OVF_FLAG_EN
    logic                            ovf_clr;
    logic [NUM_LANES-1:0]            ovf_flag;
`endif

    modport master (
        output car_arrive,
        output lane_green,
`ifdef CAR_OVF_FLAG_EN
        output ovf_clr,
        input  ovf_flag,
`endif
        input  car_counts,
        input  lane_busy
    );

    modport slave (
        input  car_arrive,
        input  lane_green,
`ifdef CAR_OVF_FLAG_EN
        input  ovf_clr,
        output ovf_flag,
`endif
        output car_counts,
        output lane_busy
    );
endinterface

// File: rtl/lane_car_counter_lane_counter.sv
// One lane: arrival edge detect, green-time departure timer, saturating queue count.
// CAR_OVF_FLAG_EN adds a sticky flag for arrivals dropped at saturation.
module lane_counter #(
    parameter int CNT_W         = 8,
    parameter int DEPART_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car_arrive_i,
    input  logic             lane_green_i,
`ifdef CAR_OVF_FLAG_EN
    input  logic             ovf_clr_i,
    output logic             ovf_flag_o,
`endif
    output logic [CNT_W-1:0] count_o,
    output logic             busy_o
);
    localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [TW-1:0]    T_LAST = TW'(DEPART_CYCLES - 1);
    localparam logic [TW-1:0]    T_ONE  = TW'(1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MAX  = '1;

    // armed_q means a 0 has been sampled since the last counted arrival (or reset)
    logic             armed_q, armed_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q;
    logic             arrive_evt, depart_evt;

    always_comb begin
        arrive_evt = car_arrive_i & armed_q;
        depart_evt = lane_green_i && (timer_q == T_LAST);
        armed_d    = ~car_arrive_i;

        if (!lane_green_i || depart_evt) timer_d = '0;
        else                             timer_d = timer_q + T_ONE;

        count_d = count_q;
        if (arrive_evt && !depart_evt) begin
            if (count_q != C_MAX) count_d = count_q + C_ONE;
        end else if (depart_evt && !arrive_evt) begin
            if (count_q != '0) count_d = count_q - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            timer_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            armed_q <= armed_d;
            timer_q <= timer_d;
            count_q <= count_d;
            busy_q  <= (count_d != '0);
        end
    end

    assign count_o = count_q;
    assign busy_o  = busy_q;

`ifdef CAR_OVF_FLAG_EN
    logic ovf_q, ovf_d, drop_evt;

    assign drop_evt = arrive_evt & ~depart_evt & (count_q == C_MAX);

    always_comb begin
        ovf_d = ovf_q;
        if (drop_evt)       ovf_d = 1'b1;
        else if (ovf_clr_i) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf_flag_o = ovf_q;
`endif
endmodule

// File: rtl/lane_car_counter.sv
// Per-lane vehicle counter feeding the DayTime carCounts bus and absorbing its laneOutput.
// CAR_OVF_FLAG_EN enables per-lane sticky overflow flags with a common clear.
module lane_car_counter
    import lane_car_counter_pkg::*;
#(
    parameter int DEPART_CYCLES = DEPART_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    lane_car_counter_if.slave  bus
);
    car_cnt_t [NUM_LANES-1:0] counts;
    logic     [NUM_LANES-1:0] busy;
`ifdef CAR_OVF_FLAG_EN
    logic     [NUM_LANES-1:0] ovf;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_counter #(
            .CNT_W         (CNT_W),
            .DEPART_CYCLES (DEPART_CYCLES)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .car_arrive_i (bus.car_arrive[g]),
            .lane_green_i (bus.lane_green[g]),
`ifdef CAR_OVF_FLAG_EN
            .ovf_clr_i    (bus.ovf_clr),
            .ovf_flag_o   (ovf[g]),
`endif
            .count_o      (counts[g]),
            .busy_o       (busy[g])
        );
    end

    assign bus.car_counts = counts;
    assign bus.lane_busy  = busy;
`ifdef CAR_OVF_FLAG_EN
    assign bus.ovf_flag   = ovf;
`endif
endmodule

// File: tb/tb_lane_car_counter.sv
// Randomized and directed checks of lane_car_counter against a per-lane queue model.
// Define CAR_OVF_FLAG_EN to also check the overflow flags.
module tb_lane_car_counter;
    import lane_car_counter_pkg::*;

    localparam int DC   = DEPART_CYCLES_DEF;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    lane_car_counter_if bus();

    lane_car_counter #(.DEPART_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: queue length, whether a 0 was seen since last arrival, consecutive green cycles
    int cnt   [NUM_LANES];
    bit armed [NUM_LANES];
    int run   [NUM_LANES];
    bit ovf   [NUM_LANES];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] arr, input logic [7:0] grn, input logic r, input logic clr);
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r) begin
                cnt[i] = 0; armed[i] = 0; run[i] = 0; ovf[i] = 0;
            end else begin
                bit a, d;
                a = arr[i] && armed[i];
                armed[i] = !arr[i];
                run[i] = grn[i] ? run[i] + 1 : 0;
                d = grn[i] && (run[i] % DC == 0);
                if (a && !d && cnt[i] == MAXC) ovf[i] = 1;
                else if (clr) ovf[i] = 0;
                if (a && !d) cnt[i] = (cnt[i] < MAXC) ? cnt[i] + 1 : cnt[i];
                else if (d && !a) cnt[i] = (cnt[i] > 0) ? cnt[i] - 1 : 0;
            end
        end
    endtask

    task automatic cycle(input logic [7:0] arr, input logic [7:0] grn, input logic r, input logic clr);
        logic [63:0] exp_c;
        logic [7:0]  exp_b;
        bus.car_arrive = arr;
        bus.lane_green = grn;
        rst = r;
`ifdef CAR_OVF_FLAG_EN
        bus.ovf_clr = clr;
`endif
        @(posedge clk);
        model_step(arr, grn, r, clr);
        #1;
        exp_c = '0;
        exp_b = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            exp_c[i*CNT_W +: CNT_W] = cnt[i][CNT_W-1:0];
            exp_b[i] = (cnt[i] != 0);
        end
        check("counts", bus.car_counts, exp_c);
        check("busy", {56'b0, bus.lane_busy}, {56'b0, exp_b});
`ifdef CAR_OVF_FLAG_EN
        begin
            logic [7:0] exp_o;
            for (int i = 0; i < NUM_LANES; i++) exp_o[i] = ovf[i];
            check("ovf", {56'b0, bus.ovf_flag}, {56'b0, exp_o});
        end
`endif
    endtask

    task automatic do_reset();
        cycle(8'h00, 8'h00, 1'b1, 1'b0);
        cycle(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pulse(input int lane, input int n);
        for (int k = 0; k < n; k++) begin
            cycle(8'(1 << lane), 8'h00, 1'b0, 1'b0);
            cycle(8'h00, 8'h00, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] grn;
        bus.car_arrive = '0;
        bus.lane_green = '0;
`ifdef CAR_OVF_FLAG_EN
        bus.ovf_clr = 1'b0;
`endif
        // Reset with sensors held high: nothing counts until a 0 is sampled
        cycle(8'hFF, 8'h00, 1'b1, 1'b0);
        cycle(8'hFF, 8'h00, 1'b1, 1'b0);
        check("rst_counts", bus.car_counts, 64'h0);
        check("rst_busy", {56'b0, bus.lane_busy}, 64'h0);
        for (int k = 0; k < 3; k++) cycle(8'hFF, 8'h00, 1'b0, 1'b0);
        check("held_high", bus.car_counts, 64'h0);
        cycle(8'h00, 8'h00, 1'b0, 1'b0);
        cycle(8'hFF, 8'h00, 1'b0, 1'b0);
        check("rearm_busy", {56'b0, bus.lane_busy}, 64'hFF);
        check("rearm_counts", bus.car_counts, 64'h0101010101010101);

        // Arrivals without green
        do_reset();
        pulse(LANE_W2, 3);
        check("W2_cnt", {56'b0, bus.car_counts[LANE_W2]}, 64'd3);
        check("W2_busy", {56'b0, bus.lane_busy}, 64'h80);
        pulse(LANE_E1, 1);
        check("E1_cnt", {56'b0, bus.car_counts[LANE_E1]}, 64'd1);

        // Departures: 12 green cycles retire 3; 6 green cycles retire 1 and discard partial
        do_reset();
        pulse(LANE_N1, 5);
        for (int k = 0; k < 12; k++) cycle(8'h00, 8'h01, 1'b0, 1'b0);
        check("N1_12green", {56'b0, bus.car_counts[LANE_N1]}, 64'd2);
        do_reset();
        pulse(LANE_N1, 5);
        for (int k = 0; k < 6; k++) cycle(8'h00, 8'h01, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) cycle(8'h00, 8'h00, 1'b0, 1'b0);
        check("N1_6green", {56'b0, bus.car_counts[LANE_N1]}, 64'd4);
        for (int k = 0; k < 3; k++) cycle(8'h00, 8'h01, 1'b0, 1'b0);
        check("N1_regreen_partial", {56'b0, bus.car_counts[LANE_N1]}, 64'd4);

        // Arrival on a departure cycle nets zero; empty green lane stays 0
        do_reset();
        pulse(LANE_N1, 2);
        for (int k = 0; k < 3; k++) cycle(8'h00, 8'h03, 1'b0, 1'b0);
        cycle(8'h01, 8'h03, 1'b0, 1'b0);
        check("N1_net_zero", {56'b0, bus.car_counts[LANE_N1]}, 64'd2);
        for (int k = 0; k < 8; k++) cycle(8'h00, 8'h03, 1'b0, 1'b0);
        check("N1_drained", {56'b0, bus.car_counts[LANE_N1]}, 64'd0);
        check("N2_no_underflow", {56'b0, bus.car_counts[LANE_N2]}, 64'd0);

        // Saturation on S1
        do_reset();
        pulse(LANE_S1, MAXC + 1);
        check("S1_sat", {56'b0, bus.car_counts[LANE_S1]}, 64'd255);
`ifdef CAR_OVF_FLAG_EN
        check("S1_ovf_set", {63'b0, bus.ovf_flag[LANE_S1]}, 64'd1);
        cycle(8'h00, 8'h00, 1'b0, 1'b1);
        check("S1_ovf_clr", {63'b0, bus.ovf_flag[LANE_S1]}, 64'd0);
`endif

        // Closed loop: every lane green, queues 0,0,1,2,3,4,5,8 drain to 0
        do_reset();
        for (int i = 2; i < 7; i++) pulse(i, i - 1);
        pulse(LANE_W2, 8);
        for (int k = 0; k < DC; k++) cycle(8'h00, 8'hFF, 1'b0, 1'b0);
        check("W2_drain1", {56'b0, bus.car_counts[LANE_W2]}, 64'd7);
        for (int k = 0; k < 10 * DC; k++) cycle(8'h00, 8'hFF, 1'b0, 1'b0);
        check("loop_empty", bus.car_counts, 64'h0);
        check("loop_busy", {56'b0, bus.lane_busy}, 64'h0);

        // Random traffic with long green runs and occasional reset/clear
        grn = 8'h00;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NUM_LANES; i++)
                if ($urandom_range(0, 7) == 0) grn[i] = ~grn[i];
            cycle(8'($urandom), grn, ($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
